// File: rtl/mmio_uart_tx.sv
//==============================================================================
// Module   : mmio_uart_tx
// Purpose  : MMIO byte writes queued in a FIFO and serialised as 8N1 frames;
//            define MMIO_UART_TX_PARITY_EN to send 8E1 frames instead.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_enabled,
    input  logic [7:0] write_value,
    output logic       fifo_full,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int              c_PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_PW:0]   c_CNT_FULL = (c_PW + 1)'(FIFO_DEPTH);
    localparam logic [c_PW:0]   c_OCC_ONE  = (c_PW + 1)'(1);

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;
    logic [c_PW:0]   w_count_next;
    logic            r_full;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [7:0]      w_head;

    // Serialiser
    state_t          r_state;
    state_t          w_state_next;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_next;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            w_bit_done;
`ifdef MMIO_UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_next;
`endif

    // A full FIFO refuses writes even if a pop frees a slot on the same edge.
    assign w_push  = write_enabled && !r_full;
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_OCC_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CNT_FULL);
            if (write_enabled && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_bit_done = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = w_bit_done ? '0 : r_cnt + c_CNT_ONE;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_pop         = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_bit_next    = '0;
`ifdef MMIO_UART_TX_PARITY_EN
                    w_parity_next = ^w_head;
`endif
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_shift_next  = w_head;
                        w_bit_next    = '0;
`ifdef MMIO_UART_TX_PARITY_EN
                        w_parity_next = ^w_head;
`endif
                        w_state_next  = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The line level is derived from the upcoming state so tx stays registered.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_tx     <= w_tx_next;
`ifdef MMIO_UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign tx        = r_tx;
    assign fifo_full = r_full;
    assign overflow  = r_overflow;
    assign busy      = !w_empty || (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
//==============================================================================
// Module   : tb_mmio_uart_tx
// Purpose  : Self-checking bench for mmio_uart_tx with a frame-timeline model.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int LOGN  = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_enabled = 1'b0;
    logic [7:0] write_value = 8'h00;
    logic       fifo_full;
    logic       busy;
    logic       overflow;
    logic       tx;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enabled (write_enabled),
        .write_value   (write_value),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .overflow      (overflow),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    bit chk_en   = 1'b0;

    // Model: queue of accepted bytes plus the position inside the frame on the line.
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    byte unsigned m_byte   = 8'h00;
    int           m_pos    = 0;
    bit           m_ovf    = 1'b0;

    logic log_tx   [LOGN];
    logic log_busy [LOGN];
    logic log_full [LOGN];
    logic log_ovf  [LOGN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic exp_tx();
        int bitn;
        if (!m_active) return 1'b1;
        bitn = m_pos / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return m_byte[bitn-1];
        if (PAR && bitn == 9) return ^m_byte;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit was_full;
        cycle++;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
            chk_en   = 1'b1;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (m_active && m_pos == FRAME - 1) m_active = 1'b0;
            else if (m_active) m_pos++;
            if (!m_active && m_q.size() > 0) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (write_enabled) begin
                if (was_full) m_ovf = 1'b1;
                else m_q.push_back(write_value);
            end
        end
    end

    always @(negedge clk) begin
        log_tx[cycle % LOGN]   = tx;
        log_busy[cycle % LOGN] = busy;
        log_full[cycle % LOGN] = fifo_full;
        log_ovf[cycle % LOGN]  = overflow;
        if (chk_en) begin
            chk("model_tx", {31'd0, tx}, {31'd0, exp_tx()});
            chk("model_busy", {31'd0, busy}, {31'd0, (m_q.size() > 0) || m_active});
            chk("model_fifo_full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
            chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    function automatic logic lt(input int c); return log_tx[c % LOGN];   endfunction
    function automatic logic lb(input int c); return log_busy[c % LOGN]; endfunction
    function automatic logic lf(input int c); return log_full[c % LOGN]; endfunction
    function automatic logic lo(input int c); return log_ovf[c % LOGN];  endfunction

    // Receiver view: sample each data bit in the middle of its bit period.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = lt(s + CPB * (1 + i) + CPB / 2);
        return d;
    endfunction

    function automatic int count_low(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (lt(i) !== 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (lb(i) !== 1'b0) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] v);
        write_enabled = 1'b1;
        write_value   = v;
        tick(1);
        write_enabled = 1'b0;
    endtask

    initial begin
        int t0;

        // Reset held for three edges with a write strobed inside it
        reset = 1'b1;
        tick(1);
        wr(8'h3C);
        tick(1);
        reset = 1'b0;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        t0 = cycle;
        tick(60);
        chk("rst_no_frame", count_low(t0, cycle), 32'd0);
        chk("rst_never_busy", count_busy(t0, cycle), 32'd0);

        // Single byte 0x55
        t0 = cycle;
        wr(8'h55);
        tick(50);
        chk("sb_busy_c0", {31'd0, lb(t0)}, 32'd0);
        chk("sb_busy_c1", {31'd0, lb(t0 + 1)}, 32'd1);
        chk("sb_tx_c1", {31'd0, lt(t0 + 1)}, 32'd1);
        chk("sb_start_c2", {31'd0, lt(t0 + 2)}, 32'd0);
        chk("sb_start_c5", {31'd0, lt(t0 + 5)}, 32'd0);
        chk("sb_bit0_c6", {31'd0, lt(t0 + 6)}, 32'd1);
        chk("sb_bit0_c9", {31'd0, lt(t0 + 9)}, 32'd1);
        chk("sb_bit1_c10", {31'd0, lt(t0 + 10)}, 32'd0);
        chk("sb_bit7_c37", {31'd0, lt(t0 + 37)}, 32'd0);
        chk("sb_decode", {24'd0, decode(t0 + 2)}, 32'h55);
`ifdef MMIO_UART_TX_PARITY_EN
        chk("sb_parity_c38", {31'd0, lt(t0 + 38)}, 32'd0);
        chk("sb_stop_c42", {31'd0, lt(t0 + 42)}, 32'd1);
        chk("sb_busy_c45", {31'd0, lb(t0 + 45)}, 32'd1);
        chk("sb_busy_c46", {31'd0, lb(t0 + 46)}, 32'd0);
`else
        chk("sb_stop_c38", {31'd0, lt(t0 + 38)}, 32'd1);
        chk("sb_stop_c41", {31'd0, lt(t0 + 41)}, 32'd1);
        chk("sb_busy_c41", {31'd0, lb(t0 + 41)}, 32'd1);
        chk("sb_busy_c42", {31'd0, lb(t0 + 42)}, 32'd0);
`endif

        // Back-to-back 0x01, 0x80
        t0 = cycle;
        wr(8'h01);
        wr(8'h80);
        tick(2 * FRAME + 10);
        chk("b2b_stop1_last", {31'd0, lt(t0 + 1 + FRAME)}, 32'd1);
        chk("b2b_start2", {31'd0, lt(t0 + 2 + FRAME)}, 32'd0);
        chk("b2b_busy_gap", {31'd0, lb(t0 + 2 + FRAME)}, 32'd1);
        chk("b2b_byte1", {24'd0, decode(t0 + 2)}, 32'h01);
        chk("b2b_byte2", {24'd0, decode(t0 + 2 + FRAME)}, 32'h80);
        chk("b2b_idle_after", {31'd0, lb(t0 + 2 + 2 * FRAME)}, 32'd0);
`ifndef MMIO_UART_TX_PARITY_EN
        chk("b2b_start2_c42", {31'd0, lt(t0 + 42)}, 32'd0);
`endif

`ifdef MMIO_UART_TX_PARITY_EN
        // Parity: 0x07 has odd weight, 0x03 even weight
        t0 = cycle;
        wr(8'h07);
        tick(50);
        chk("par07_bit7", {31'd0, lt(t0 + 37)}, 32'd0);
        chk("par07_par_c38", {31'd0, lt(t0 + 38)}, 32'd1);
        chk("par07_par_c41", {31'd0, lt(t0 + 41)}, 32'd1);
        chk("par07_stop_c45", {31'd0, lt(t0 + 45)}, 32'd1);
        chk("par07_busy_c45", {31'd0, lb(t0 + 45)}, 32'd1);
        chk("par07_busy_c46", {31'd0, lb(t0 + 46)}, 32'd0);
        t0 = cycle;
        wr(8'h03);
        tick(50);
        chk("par03_par_c38", {31'd0, lt(t0 + 38)}, 32'd0);
        chk("par03_decode", {24'd0, decode(t0 + 2)}, 32'h03);
`endif

        // Overflow with a four-deep FIFO
        t0 = cycle;
        for (int k = 0; k < 6; k++) wr(8'hA0 + 8'(k));
        tick(5 * FRAME + 10);
        chk("ovf_full_c4", {31'd0, lf(t0 + 4)}, 32'd0);
        chk("ovf_full_c5", {31'd0, lf(t0 + 5)}, 32'd1);
        chk("ovf_flag_c5", {31'd0, lo(t0 + 5)}, 32'd0);
        chk("ovf_flag_c6", {31'd0, lo(t0 + 6)}, 32'd1);
        for (int k = 0; k < 5; k++)
            chk($sformatf("ovf_frame%0d", k), {24'd0, decode(t0 + 2 + k * FRAME)}, 32'hA0 + k);
        chk("ovf_no_sixth", {31'd0, lb(t0 + 2 + 5 * FRAME)}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset during bit 3 of a 0x00 frame with more bytes queued
        t0 = cycle;
        wr(8'h00);
        wr(8'h11);
        wr(8'h22);
        tick(16);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_tx_before", {31'd0, lt(t0 + 19)}, 32'd0);
        chk("mid_tx", {31'd0, tx}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_fifo_full", {31'd0, fifo_full}, 32'd0);
        chk("mid_overflow", {31'd0, overflow}, 32'd0);
        t0 = cycle;
        tick(3 * FRAME);
        chk("mid_no_frames", count_low(t0, cycle), 32'd0);
        chk("mid_never_busy", count_busy(t0, cycle), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
